// File: rtl/riscv_csr_pkg.sv
// Shared CSR addresses, mstatus field positions and WARL masks for the machine-mode CSR unit.
package riscv_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [31:0] MTVEC_WARL_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] MEPC_WARL_MASK  = 32'hFFFF_FFFC;

    // funct3[1:0] selects the operation; funct3[2] selects the immediate operand.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter built from two 32-bit halves; a write to one half overrides only that half's update.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_en_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        carry;

    // Carry comes from the pre-write low half, so a written low half still lets the high half advance.
    always_comb begin
        carry = inc_en_i && (lo_q == 32'hFFFF_FFFF);
        lo_d  = wr_lo_i ? wdata_i : lo_q + {31'b0, inc_en_i};
        hi_d  = wr_hi_i ? wdata_i : hi_q + {31'b0, carry};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign count_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR responder: zero-latency old-value read, RW/RS/RC updates, trap/MRET state and counters.
module csr_unit
    import riscv_csr_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_en,
    input  logic [2:0]      csr_funct3,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      rs1_field,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            instr_retire,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret,
    output logic [XLEN-1:0] csr_rdata,
    output logic            illegal_csr,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] epc,
    output logic            mie_out
);

    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;

    logic [63:0] mcycle, minstret;
    logic [31:0] mstatus_val, old_val, src, new_val;
    logic        known, read_only, write_req, do_write;
    csr_op_e     op;

    always_comb begin
        mstatus_val = '0;
        mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_val[MSTATUS_MIE]  = mie_q;
        mstatus_val[MSTATUS_MPIE] = mpie_q;
    end

    always_comb begin
        old_val   = '0;
        known     = 1'b1;
        read_only = 1'b0;
        case (csr_addr)
            CSR_MSTATUS:   old_val = mstatus_val;
            CSR_MTVEC:     old_val = mtvec_q;
            CSR_MSCRATCH:  old_val = mscratch_q;
            CSR_MEPC:      old_val = mepc_q;
            CSR_MCAUSE:    old_val = mcause_q;
            CSR_MCYCLE:    old_val = mcycle[31:0];
            CSR_MCYCLEH:   old_val = mcycle[63:32];
            CSR_MINSTRET:  old_val = minstret[31:0];
            CSR_MINSTRETH: old_val = minstret[63:32];
            CSR_CYCLE:     begin old_val = mcycle[31:0];    read_only = 1'b1; end
            CSR_CYCLEH:    begin old_val = mcycle[63:32];   read_only = 1'b1; end
            CSR_INSTRET:   begin old_val = minstret[31:0];  read_only = 1'b1; end
            CSR_INSTRETH:  begin old_val = minstret[63:32]; read_only = 1'b1; end
            CSR_MHARTID:   begin old_val = HART_ID;         read_only = 1'b1; end
            default:       known = 1'b0;
        endcase
    end

    // Set/clear with a zero rs1 field is a pure read and must not trip the read-only check.
    always_comb begin
        op          = csr_op_e'(csr_funct3[1:0]);
        write_req   = (op == OP_RW) || (rs1_field != 5'd0);
        illegal_csr = csr_en && (!known || (op == OP_NONE) || (read_only && write_req));
        do_write    = csr_en && write_req && !illegal_csr && !trap_valid;
        src         = csr_funct3[2] ? {27'b0, rs1_field} : rs1_data;
        case (op)
            OP_RS:   new_val = old_val | src;
            OP_RC:   new_val = old_val & ~src;
            default: new_val = src;
        endcase
    end

    always_comb begin
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mscratch_d = mscratch_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        if (trap_valid) begin
            mepc_d   = trap_pc & MEPC_WARL_MASK;
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else begin
            if (mret) begin
                mie_d  = mpie_q;
                mpie_d = 1'b1;
            end else if (do_write && csr_addr == CSR_MSTATUS) begin
                mie_d  = new_val[MSTATUS_MIE];
                mpie_d = new_val[MSTATUS_MPIE];
            end
            if (do_write && csr_addr == CSR_MTVEC)    mtvec_d    = new_val & MTVEC_WARL_MASK;
            if (do_write && csr_addr == CSR_MSCRATCH) mscratch_d = new_val;
            if (do_write && csr_addr == CSR_MEPC)     mepc_d     = new_val & MEPC_WARL_MASK;
            if (do_write && csr_addr == CSR_MCAUSE)   mcause_d   = new_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtvec_q    <= MTVEC_RESET;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mscratch_q <= '0;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
        end else begin
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mscratch_q <= mscratch_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_en_i (1'b1),
        .wr_lo_i  (do_write && csr_addr == CSR_MCYCLE),
        .wr_hi_i  (do_write && csr_addr == CSR_MCYCLEH),
        .wdata_i  (new_val),
        .count_o  (mcycle)
    );

    csr_counter64 u_minstret (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_en_i (instr_retire && !trap_valid),
        .wr_lo_i  (do_write && csr_addr == CSR_MINSTRET),
        .wr_hi_i  (do_write && csr_addr == CSR_MINSTRETH),
        .wdata_i  (new_val),
        .count_o  (minstret)
    );

    assign csr_rdata   = old_val;
    assign trap_vector = mtvec_q;
    assign epc         = mepc_q;
    assign mie_out     = mie_q;

endmodule
